curlimit_cond: RTL and testbench

Conditions the analogue over-current comparator into the `currentlimit` input of the 8-bit PWM channel. It sits directly upstream of that channel. It synchronises the comparator and ignores it during a programmable leading-edge blanking window after each PWM turn-on. It then digitally filters the comparator, issues a cycle-by-cycle current-limit pulse, and latches a hard fault after too many consecutive limited periods.

---
 rtl/curlimit_pkg.sv | 24 ++
 rtl/curlimit_cond_sync2.sv | 24 ++
 rtl/curlimit_cond.sv | 174 +++++++++++++++++
 tb/tb_curlimit_cond.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/curlimit_pkg.sv
// rtl/curlimit_pkg.sv - shared types and default constants for the current-limit conditioner
package curlimit_pkg;

  // Conditioner FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BLANK   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_TRIPPED = 3'd3,
    ST_FAULT   = 3'd4
  } cl_state_t;

  // Default parameter values
  localparam int DEF_FILT_LEN    = 3;
  localparam int DEF_FAULT_LIMIT = 8;
  localparam int DEF_TCW         = 4;

  // Filter counter width: enough for FILT_LEN up to 15
  localparam int FCW = 4;

  // Blanking counter width, matches the blanktime input
  localparam int BCW = 8;

endpackage

// File: rtl/curlimit_cond_sync2.sv
// rtl/curlimit_cond_sync2.sv - generic two-flop synchroniser with synchronous active-low reset
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two flop stages; the first may go metastable, the second resolves it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/curlimit_cond.sv
// rtl/curlimit_cond.sv - over-current comparator conditioner feeding the PWM channel currentlimit input
module curlimit_cond
  import curlimit_pkg::*;
#(
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int FAULT_LIMIT = DEF_FAULT_LIMIT,
  parameter int TCW         = DEF_TCW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           pwmon,
  input  logic           cmp,
  input  logic [BCW-1:0] blanktime,
  input  logic           clearfault,
  output logic           currentlimit,
  output logic           fault,
  output logic [TCW-1:0] tripcnt
);

  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
  localparam logic [TCW-1:0] FAULT_LIM = TCW'(FAULT_LIMIT);
  localparam logic [TCW-1:0] TRIP_MAX  = {TCW{1'b1}};
  localparam bit             FAULT_EN  = (FAULT_LIMIT != 0);

  cl_state_t      state, state_n;
  logic [BCW-1:0] blank_cnt, blank_n;
  logic [FCW-1:0] filt_cnt, filt_n;
  logic [TCW-1:0] trip_n;
  logic           tripped_this_period, ttp_n;
  logic           cl_n, fault_n;
  logic           pwmon_d;
  logic           cmp_s;
  logic           rise, fall;

  sync2 #(.W(1)) u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp),
    .q     (cmp_s)
  );

  assign rise = pwmon & ~pwmon_d;
  assign fall = ~pwmon & pwmon_d;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      blank_cnt           <= '0;
      filt_cnt            <= '0;
      tripcnt             <= '0;
      tripped_this_period <= 1'b0;
      currentlimit        <= 1'b0;
      fault               <= 1'b0;
      pwmon_d             <= 1'b0;
    end else begin
      state               <= state_n;
      blank_cnt           <= blank_n;
      filt_cnt            <= filt_n;
      tripcnt             <= trip_n;
      tripped_this_period <= ttp_n;
      currentlimit        <= cl_n;
      fault               <= fault_n;
      pwmon_d             <= pwmon;
    end
  end

  // Next-state and next-output logic, evaluated in edge priority order
  always_comb begin
    state_n = state;
    blank_n = blank_cnt;
    filt_n  = filt_cnt;
    trip_n  = tripcnt;
    ttp_n   = tripped_this_period;
    cl_n    = currentlimit;
    fault_n = fault;

    if (state == ST_FAULT && clearfault) begin
      state_n = ST_IDLE;
      filt_n  = '0;
      trip_n  = '0;
      ttp_n   = 1'b0;
      cl_n    = 1'b0;
      fault_n = 1'b0;
    end else if (!enable) begin
      // Disable clears the counters but a latched fault survives it
      filt_n = '0;
      trip_n = '0;
      ttp_n  = 1'b0;
      if (state != ST_FAULT) begin
        state_n = ST_IDLE;
        cl_n    = 1'b0;
      end
    end else if (state == ST_FAULT) begin
      // Latched: only clearfault or reset leaves, the trip count is frozen
      cl_n    = 1'b1;
      fault_n = 1'b1;
    end else if (FAULT_EN && tripcnt == FAULT_LIM) begin
      state_n = ST_FAULT;
      cl_n    = 1'b1;
      fault_n = 1'b1;
    end else begin
      // A period that finished without tripping breaks the consecutive run
      if (rise) begin
        ttp_n = 1'b0;
        if (!tripped_this_period) begin
          trip_n = '0;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (rise) begin
            filt_n = '0;
            if (blanktime == '0) begin
              state_n = ST_ARMED;
            end else begin
              blank_n = blanktime;
              state_n = ST_BLANK;
            end
          end
        end

        ST_BLANK: begin
          if (fall) begin
            state_n = ST_IDLE;
            filt_n  = '0;
          end else begin
            blank_n = blank_cnt - BCW'(1);
            if (blank_cnt <= BCW'(1)) begin
              state_n = ST_ARMED;
            end
          end
        end

        ST_ARMED: begin
          if (fall) begin
            state_n = ST_IDLE;
            filt_n  = '0;
          end else if (cmp_s) begin
            if (filt_cnt == FILT_LAST) begin
              state_n = ST_TRIPPED;
              filt_n  = '0;
              cl_n    = 1'b1;
              ttp_n   = 1'b1;
              if (tripcnt != TRIP_MAX) begin
                trip_n = tripcnt + TCW'(1);
              end
            end else begin
              filt_n = filt_cnt + FCW'(1);
            end
          end else begin
            filt_n = '0;
          end
        end

        ST_TRIPPED: begin
          // Release one edge after fall so the channel sees it low at period start
          if (fall) begin
            state_n = ST_IDLE;
            cl_n    = 1'b0;
          end
        end

        default: begin
          state_n = ST_IDLE;
          cl_n    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_curlimit_cond.sv
// tb/tb_curlimit_cond.sv - scoreboard bench for curlimit_cond with a period-level reference model
module tb_curlimit_cond;

  localparam int FILT_LEN    = 3;
  localparam int FAULT_LIMIT = 8;
  localparam int TCW         = 4;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic           pwmon;
  logic           cmp;
  logic [7:0]     blanktime;
  logic           clearfault;
  logic           currentlimit;
  logic           fault;
  logic [TCW-1:0] tripcnt;

  curlimit_cond #(
    .FILT_LEN    (FILT_LEN),
    .FAULT_LIMIT (FAULT_LIMIT),
    .TCW         (TCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pwmon        (pwmon),
    .cmp          (cmp),
    .blanktime    (blanktime),
    .clearfault   (clearfault),
    .currentlimit (currentlimit),
    .fault        (fault),
    .tripcnt      (tripcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic           cl;
    logic           flt;
    logic [TCW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: tracks a PWM period as "watching" with a blanking
  // countdown and a run length of high comparator samples, plus a limited flag
  bit m_p1, m_p2, m_prev;
  bit m_watch, m_limited, m_fault, m_hit;
  int m_blank_left, m_run, m_cnt;

  task automatic model_edge();
    bit rise, fall, cs;
    rise = pwmon && !m_prev;
    fall = !pwmon && m_prev;
    cs   = m_p2;
    if (!rst_n) begin
      m_p1 = 0; m_p2 = 0; m_prev = 0;
      m_watch = 0; m_limited = 0; m_fault = 0; m_hit = 0;
      m_blank_left = 0; m_run = 0; m_cnt = 0;
    end else begin
      if (m_fault && clearfault) begin
        m_fault = 0; m_limited = 0; m_watch = 0; m_run = 0; m_cnt = 0; m_hit = 0;
      end else if (!enable) begin
        m_run = 0; m_cnt = 0; m_hit = 0;
        if (!m_fault) begin
          m_watch = 0; m_limited = 0;
        end
      end else if (m_fault) begin
        m_fault = 1;
      end else if (FAULT_LIMIT > 0 && m_cnt >= FAULT_LIMIT) begin
        m_fault = 1;
      end else begin
        if (rise) begin
          if (!m_hit) m_cnt = 0;
          m_hit = 0;
        end
        if (m_limited) begin
          if (fall) m_limited = 0;
        end else if (m_watch) begin
          if (fall) begin
            m_watch = 0; m_run = 0;
          end else if (m_blank_left > 0) begin
            m_blank_left--;
          end else if (cs) begin
            m_run++;
            if (m_run >= FILT_LEN) begin
              m_limited = 1; m_watch = 0; m_run = 0; m_hit = 1;
              if (m_cnt < (1 << TCW) - 1) m_cnt++;
            end
          end else begin
            m_run = 0;
          end
        end else if (rise) begin
          m_watch = 1; m_run = 0; m_blank_left = blanktime;
        end
      end
      m_p2 = m_p1;
      m_p1 = cmp;
      m_prev = pwmon;
    end
  endtask

  // Apply current inputs for one posedge: predict, enqueue, move to next negedge
  task automatic cyc();
    exp_t e;
    model_edge();
    e.cl  = m_limited | m_fault;
    e.flt = m_fault;
    e.cnt = TCW'(m_cnt);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per clock and compares just after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (currentlimit !== e.cl) begin
        miscompares++;
        $display("FAIL currentlimit vec %0d t=%0t: got %b want %b", vectors, $time, currentlimit, e.cl);
      end
      if (fault !== e.flt) begin
        miscompares++;
        $display("FAIL fault vec %0d t=%0t: got %b want %b", vectors, $time, fault, e.flt);
      end
      if (tripcnt !== e.cnt) begin
        miscompares++;
        $display("FAIL tripcnt vec %0d t=%0t: got %0d want %0d", vectors, $time, tripcnt, e.cnt);
      end
    end
  end

  task automatic do_reset();
    rst_n = 0; enable = 1; pwmon = 0; cmp = 0; clearfault = 0; blanktime = 8'd0;
    cyc();
    cyc();
    rst_n = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pwmon = 0; cmp = 0;
      cyc();
    end
  endtask

  // One PWM period; cmp high on [cmp_from, cmp_to) or periodic 2-of-5 glitches
  task automatic run_period(input int on_len, input int off_len, input int bt,
                            input int cmp_from, input int cmp_to, input bit glitch);
    for (int i = 0; i < on_len; i++) begin
      pwmon = 1;
      blanktime = 8'(bt);
      if (glitch) cmp = (i >= 3) && ((i % 5) < 2);
      else        cmp = (i >= cmp_from) && (i < cmp_to);
      cyc();
    end
    idle(off_len);
  endtask

  initial begin
    int left;
    rst_n = 0; enable = 1; pwmon = 0; cmp = 0; clearfault = 0; blanktime = 8'd0;

    do_reset();
    idle(3);

    // Blanking hides a comparator that is high early in the period
    run_period(40, 10, 10, 0, 9, 0);

    // Trip latency with no blanking, released after fall
    do_reset();
    run_period(30, 10, 0, 5, 30, 0);

    // Short glitches never trip
    do_reset();
    run_period(60, 10, 0, 0, 0, 1);

    // Eight consecutive trips latch a fault, then clearfault
    do_reset();
    for (int p = 0; p < 8; p++) run_period(20, 6, 2, 5, 20, 0);
    idle(4);
    clearfault = 1; cyc();
    clearfault = 0;
    idle(5);

    // Five trips then clean periods reset the count
    do_reset();
    for (int p = 0; p < 5; p++) run_period(20, 6, 2, 5, 20, 0);
    for (int p = 0; p < 2; p++) run_period(20, 6, 2, 0, 0, 0);

    // Enable dropped while tripped
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pwmon = 1; blanktime = 8'd0; cmp = (i >= 5); enable = (i != 15);
      cyc();
    end
    enable = 1;
    idle(6);

    // Reset while latched in fault
    for (int p = 0; p < 8; p++) run_period(20, 6, 1, 4, 20, 0);
    idle(3);
    rst_n = 0; cyc();
    rst_n = 1;
    idle(3);

    // Randomised traffic
    do_reset();
    left = 5;
    for (int k = 0; k < 3000; k++) begin
      if (left == 0) begin
        pwmon = ~pwmon;
        left = $urandom_range(3, 30);
      end else begin
        left--;
      end
      if ($urandom_range(0, 9) < 2) cmp = ~cmp;
      blanktime  = 8'($urandom_range(0, 6));
      enable     = ($urandom_range(0, 99) != 0);
      clearfault = ($urandom_range(0, 39) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst_n = 1; enable = 1; clearfault = 0;
    idle(4);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
